// File: rtl/recon_dma_scheduler.sv
// Partial-reconfiguration load scheduler: bitstream table, round-robin request arbiter and single-outstanding DMA descriptor FSM.
// Optional completion timeout is built when RECON_SCHED_TIMEOUT_EN is defined.
module recon_dma_scheduler #(
   parameter int ADDR_WIDTH     = 34,
   parameter int LEN_WIDTH      = 20,
   parameter int TAG_WIDTH      = 8,
   parameter int ID_COUNT       = 16,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int REQ_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int IDX_W         = (ID_COUNT > 1) ? $clog2(ID_COUNT) : 1
) (
   input  logic                   s_axis_clk,
   input  logic                   rst,
   input  logic                   tbl_wr_valid,
   input  logic [7:0]             tbl_wr_id,
   input  logic [ADDR_WIDTH-1:0]  tbl_wr_addr,
   input  logic [LEN_WIDTH-1:0]   tbl_wr_size,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*8-1:0]   req_id,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [ADDR_WIDTH-1:0]  m_desc_addr,
   output logic [LEN_WIDTH-1:0]   m_desc_len,
   output logic [TAG_WIDTH-1:0]   m_desc_tag,
   output logic                   m_desc_valid,
   input  logic                   m_desc_ready,
   input  logic [TAG_WIDTH-1:0]   s_status_tag,
   input  logic [3:0]             s_status_error,
   input  logic                   s_status_valid,
   output logic                   rsp_valid,
   output logic [REQ_W-1:0]       rsp_req,
   output logic [1:0]             rsp_status,
   output logic                   busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_ISSUE,
      ST_WAIT_CPL,
      ST_RESPOND
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              id_q, id_d;
   logic [REQ_W-1:0]        req_idx_q, req_idx_d;
   logic [REQ_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [TAG_WIDTH-1:0]    tag_cnt_q, tag_cnt_d;
   logic [ADDR_WIDTH-1:0]   m_desc_addr_q, m_desc_addr_d;
   logic [LEN_WIDTH-1:0]    m_desc_len_q, m_desc_len_d;
   logic [TAG_WIDTH-1:0]    m_desc_tag_q, m_desc_tag_d;
   logic                    m_desc_valid_q, m_desc_valid_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [REQ_W-1:0]        rsp_req_q, rsp_req_d;
   logic [1:0]              rsp_status_q, rsp_status_d;

   logic [ID_COUNT-1:0]     tbl_valid_q, tbl_valid_d;
   logic [ADDR_WIDTH-1:0]   tbl_addr_q [ID_COUNT];
   logic [ADDR_WIDTH-1:0]   tbl_addr_d [ID_COUNT];
   logic [LEN_WIDTH-1:0]    tbl_size_q [ID_COUNT];
   logic [LEN_WIDTH-1:0]    tbl_size_d [ID_COUNT];

   logic                    grant_found;
   logic [REQ_W-1:0]        grant_idx;
   logic [7:0]              grant_id;
   logic                    wr_in_range;
   logic [IDX_W-1:0]        wr_idx;
   logic [IDX_W-1:0]        lu_idx;
   logic                    lu_bypass;
   logic                    lu_hit;
   logic [ADDR_WIDTH-1:0]   lu_addr;
   logic [LEN_WIDTH-1:0]    lu_size;

`ifdef RECON_SCHED_TIMEOUT_EN
   localparam logic [31:0]  TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
   logic [31:0]             to_cnt_q, to_cnt_d;
`else
   logic                    unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

   assign wr_idx      = tbl_wr_id[IDX_W-1:0];
   assign wr_in_range = (int'(tbl_wr_id) < ID_COUNT);

   always_comb begin
      tbl_valid_d = tbl_valid_q;
      tbl_addr_d  = tbl_addr_q;
      tbl_size_d  = tbl_size_q;
      if (tbl_wr_valid && wr_in_range) begin
         tbl_valid_d[wr_idx] = (tbl_wr_size != '0);
         tbl_addr_d[wr_idx]  = tbl_wr_addr;
         tbl_size_d[wr_idx]  = tbl_wr_size;
      end
   end

   // Round-robin: scan requesters in order starting at the pointer.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && req_valid[j] && (((int'(rr_ptr_q) + i) % NUM_REQ) == j)) begin
               grant_found = 1'b1;
               grant_idx   = REQ_W'(j);
            end
         end
      end
   end

   always_comb begin
      grant_id  = '0;
      req_ready = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_idx == REQ_W'(j)) begin
            grant_id = req_id[j*8 +: 8];
         end
         req_ready[j] = (state_q == ST_IDLE) && grant_found && (grant_idx == REQ_W'(j));
      end
   end

   // A write to the entry being looked up in the same cycle wins over the stored copy.
   always_comb begin
      lu_idx    = id_q[IDX_W-1:0];
      lu_bypass = tbl_wr_valid && (tbl_wr_id == id_q);
      lu_addr   = lu_bypass ? tbl_wr_addr : tbl_addr_q[lu_idx];
      lu_size   = lu_bypass ? tbl_wr_size : tbl_size_q[lu_idx];
      lu_hit    = (int'(id_q) < ID_COUNT) &&
                  (lu_bypass ? (tbl_wr_size != '0) : tbl_valid_q[lu_idx]);
   end

   always_comb begin
      state_d        = state_q;
      id_d           = id_q;
      req_idx_d      = req_idx_q;
      rr_ptr_d       = rr_ptr_q;
      tag_cnt_d      = tag_cnt_q;
      m_desc_addr_d  = m_desc_addr_q;
      m_desc_len_d   = m_desc_len_q;
      m_desc_tag_d   = m_desc_tag_q;
      m_desc_valid_d = m_desc_valid_q;
      rsp_valid_d    = 1'b0;
      rsp_req_d      = rsp_req_q;
      rsp_status_d   = rsp_status_q;
`ifdef RECON_SCHED_TIMEOUT_EN
      to_cnt_d       = to_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               id_d      = grant_id;
               req_idx_d = grant_idx;
               rr_ptr_d  = (grant_idx == REQ_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
               state_d   = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (lu_hit) begin
               m_desc_addr_d  = lu_addr;
               m_desc_len_d   = lu_size;
               m_desc_tag_d   = tag_cnt_q;
               m_desc_valid_d = 1'b1;
               state_d        = ST_ISSUE;
            end else begin
               rsp_valid_d  = 1'b1;
               rsp_req_d    = req_idx_q;
               rsp_status_d = 2'd1;
               state_d      = ST_RESPOND;
            end
         end
         ST_ISSUE: begin
            if (m_desc_ready) begin
               m_desc_valid_d = 1'b0;
               tag_cnt_d      = tag_cnt_q + 1'b1;
               state_d        = ST_WAIT_CPL;
`ifdef RECON_SCHED_TIMEOUT_EN
               to_cnt_d       = '0;
`endif
            end
         end
         ST_WAIT_CPL: begin
`ifdef RECON_SCHED_TIMEOUT_EN
            to_cnt_d = to_cnt_q + 32'd1;
`endif
            if (s_status_valid && (s_status_tag == m_desc_tag_q)) begin
               rsp_valid_d  = 1'b1;
               rsp_req_d    = req_idx_q;
               rsp_status_d = (s_status_error != 4'd0) ? 2'd2 : 2'd0;
               state_d      = ST_RESPOND;
            end
`ifdef RECON_SCHED_TIMEOUT_EN
            else if (to_cnt_d == TIMEOUT_LIMIT) begin
               rsp_valid_d  = 1'b1;
               rsp_req_d    = req_idx_q;
               rsp_status_d = 2'd3;
               state_d      = ST_RESPOND;
            end
`endif
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge s_axis_clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         id_q           <= '0;
         req_idx_q      <= '0;
         rr_ptr_q       <= '0;
         tag_cnt_q      <= '0;
         m_desc_addr_q  <= '0;
         m_desc_len_q   <= '0;
         m_desc_tag_q   <= '0;
         m_desc_valid_q <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_req_q      <= '0;
         rsp_status_q   <= '0;
         tbl_valid_q    <= '0;
`ifdef RECON_SCHED_TIMEOUT_EN
         to_cnt_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         id_q           <= id_d;
         req_idx_q      <= req_idx_d;
         rr_ptr_q       <= rr_ptr_d;
         tag_cnt_q      <= tag_cnt_d;
         m_desc_addr_q  <= m_desc_addr_d;
         m_desc_len_q   <= m_desc_len_d;
         m_desc_tag_q   <= m_desc_tag_d;
         m_desc_valid_q <= m_desc_valid_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_req_q      <= rsp_req_d;
         rsp_status_q   <= rsp_status_d;
         tbl_valid_q    <= tbl_valid_d;
`ifdef RECON_SCHED_TIMEOUT_EN
         to_cnt_q       <= to_cnt_d;
`endif
      end
   end

   // Address and size payload needs no reset; the valid bits gate every use.
   always_ff @(posedge s_axis_clk) begin
      tbl_addr_q <= tbl_addr_d;
      tbl_size_q <= tbl_size_d;
   end

   assign m_desc_addr  = m_desc_addr_q;
   assign m_desc_len   = m_desc_len_q;
   assign m_desc_tag   = m_desc_tag_q;
   assign m_desc_valid = m_desc_valid_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_req      = rsp_req_q;
   assign rsp_status   = rsp_status_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_recon_dma_scheduler.sv
// Self-checking bench for recon_dma_scheduler: directed scenarios followed by randomized
// requests, all compared against a table/arbiter/tag reference model kept in the bench.
module tb_recon_dma_scheduler;

   localparam int AW  = 34;
   localparam int LW  = 20;
   localparam int TW  = 8;
   localparam int IDC = 16;
   localparam int NR  = 2;
   localparam int TO  = 100;

   logic              clock = 1'b0;
   logic              rst;
   logic              tbl_wr_valid;
   logic [7:0]        tbl_wr_id;
   logic [AW-1:0]     tbl_wr_addr;
   logic [LW-1:0]     tbl_wr_size;
   logic [NR-1:0]     req_valid;
   logic [NR*8-1:0]   req_id;
   logic [NR-1:0]     req_ready;
   logic [AW-1:0]     m_desc_addr;
   logic [LW-1:0]     m_desc_len;
   logic [TW-1:0]     m_desc_tag;
   logic              m_desc_valid;
   logic              m_desc_ready;
   logic [TW-1:0]     s_status_tag;
   logic [3:0]        s_status_error;
   logic              s_status_valid;
   logic              rsp_valid;
   logic [0:0]        rsp_req;
   logic [1:0]        rsp_status;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // Reference model: table contents, round-robin pointer and next tag.
   logic [AW-1:0] mAddr [IDC];
   logic [LW-1:0] mSize [IDC];
   bit            mValid [IDC];
   int            mRr;
   int            mTag;

   always #5 clock = ~clock;

   recon_dma_scheduler #(
      .ADDR_WIDTH     (AW),
      .LEN_WIDTH      (LW),
      .TAG_WIDTH      (TW),
      .ID_COUNT       (IDC),
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .s_axis_clk     (clock),
      .rst            (rst),
      .tbl_wr_valid   (tbl_wr_valid),
      .tbl_wr_id      (tbl_wr_id),
      .tbl_wr_addr    (tbl_wr_addr),
      .tbl_wr_size    (tbl_wr_size),
      .req_valid      (req_valid),
      .req_id         (req_id),
      .req_ready      (req_ready),
      .m_desc_addr    (m_desc_addr),
      .m_desc_len     (m_desc_len),
      .m_desc_tag     (m_desc_tag),
      .m_desc_valid   (m_desc_valid),
      .m_desc_ready   (m_desc_ready),
      .s_status_tag   (s_status_tag),
      .s_status_error (s_status_error),
      .s_status_valid (s_status_valid),
      .rsp_valid      (rsp_valid),
      .rsp_req        (rsp_req),
      .rsp_status     (rsp_status),
      .busy           (busy)
   );

   // Every comparison funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < IDC; i++) begin
         mValid[i] = 1'b0;
         mAddr[i]  = '0;
         mSize[i]  = '0;
      end
      mRr  = 0;
      mTag = 0;
   endtask

   task automatic modelWrite(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] size);
      if (id < IDC) begin
         mValid[id] = (size != 0);
         mAddr[id]  = addr;
         mSize[id]  = size;
      end
   endtask

   function automatic logic [AW-1:0] randAddr();
      logic [1:0]  hi;
      logic [31:0] lo;
      hi = 2'($urandom_range(3, 0));
      lo = $urandom;
      return {hi, lo};
   endfunction

   // Called at a negedge; leaves the bench at the following negedge.
   task automatic writeEntry(input logic [7:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] size);
      tbl_wr_valid = 1'b1;
      tbl_wr_id    = id;
      tbl_wr_addr  = addr;
      tbl_wr_size  = size;
      @(negedge clock);
      tbl_wr_valid = 1'b0;
      modelWrite(int'(id), addr, size);
   endtask

   task automatic applyReset();
      rst            = 1'b1;
      tbl_wr_valid   = 1'b0;
      req_valid      = '0;
      m_desc_ready   = 1'b0;
      s_status_valid = 1'b0;
      repeat (2) @(negedge clock);
      rst = 1'b0;
      modelReset();
   endtask

   // One complete request from grant to response, with optional stalls, bypass writes,
   // writes during ISSUE and a stray wrong-tag completion.
   task automatic applyStimulus(input logic [1:0] mask, input logic [7:0] id0, input logic [7:0] id1,
                                input int readyDelay, input int bypassMode, input bit writeInIssue,
                                input bit wrongTag, input logic [3:0] err);
      int            win;
      int            k;
      int            widx;
      logic [7:0]    wid;
      bit            good;
      logic [AW-1:0] eAddr;
      logic [LW-1:0] eLen;
      logic [TW-1:0] eTag;
      logic [1:0]    eStatus;

      checkOutput("idle_busy", busy, 0);
      req_valid = mask;
      req_id    = {id1, id0};
      #1;
      win = -1;
      for (int i = 0; i < NR; i++) begin
         k = (mRr + i) % NR;
         if (win < 0 && mask[k]) win = k;
      end
      checkOutput("grant", req_ready, 64'(1 << win));
      mRr  = (win + 1) % NR;
      wid  = (win == 0) ? id0 : id1;
      widx = int'(wid);

      @(negedge clock);
      checkOutput("lookup_no_grant", req_ready, 0);
      checkOutput("lookup_busy", busy, 1);
      req_valid = '0;
      if (bypassMode != 0 && widx < IDC) begin
         tbl_wr_valid = 1'b1;
         tbl_wr_id    = wid;
         tbl_wr_addr  = randAddr();
         tbl_wr_size  = (bypassMode == 1) ? LW'($urandom_range(1048575, 1)) : '0;
         modelWrite(widx, tbl_wr_addr, tbl_wr_size);
      end
      good  = (widx < IDC) ? mValid[widx % IDC] : 1'b0;
      eAddr = mAddr[widx % IDC];
      eLen  = mSize[widx % IDC];

      @(negedge clock);
      tbl_wr_valid = 1'b0;
      if (!good) begin
         checkOutput("bad_rsp_valid", rsp_valid, 1);
         checkOutput("bad_rsp_status", rsp_status, 1);
         checkOutput("bad_rsp_req", rsp_req, 64'(win));
         checkOutput("bad_no_desc", m_desc_valid, 0);
         @(negedge clock);
         checkOutput("bad_rsp_drop", rsp_valid, 0);
         checkOutput("bad_status_hold", rsp_status, 1);
         checkOutput("bad_idle", busy, 0);
         return;
      end

      checkOutput("desc_valid", m_desc_valid, 1);
      checkOutput("desc_addr", m_desc_addr, eAddr);
      checkOutput("desc_len", m_desc_len, eLen);
      checkOutput("desc_tag", m_desc_tag, 64'(mTag));
      for (int c = 0; c < readyDelay; c++) begin
         if (c == 0 && writeInIssue) begin
            tbl_wr_valid = 1'b1;
            tbl_wr_id    = wid;
            tbl_wr_addr  = eAddr ^ 34'h3_0000_1000;
            tbl_wr_size  = eLen ^ 20'h00010;
            modelWrite(widx, tbl_wr_addr, tbl_wr_size);
         end
         @(negedge clock);
         tbl_wr_valid = 1'b0;
         checkOutput("stall_valid", m_desc_valid, 1);
         checkOutput("stall_addr", m_desc_addr, eAddr);
         checkOutput("stall_len", m_desc_len, eLen);
         checkOutput("stall_tag", m_desc_tag, 64'(mTag));
      end
      m_desc_ready = 1'b1;
      @(negedge clock);
      m_desc_ready = 1'b0;
      checkOutput("desc_single_hs", m_desc_valid, 0);
      checkOutput("wait_busy", busy, 1);
      eTag = TW'(mTag);
      mTag = (mTag + 1) % 256;

      if (wrongTag) begin
         s_status_valid = 1'b1;
         s_status_tag   = eTag + 8'd1;
         s_status_error = 4'd0;
         @(negedge clock);
         s_status_valid = 1'b0;
         checkOutput("wrong_tag_ignored", rsp_valid, 0);
         checkOutput("wrong_tag_busy", busy, 1);
      end
      s_status_valid = 1'b1;
      s_status_tag   = eTag;
      s_status_error = err;
      eStatus        = (err != 0) ? 2'd2 : 2'd0;
      @(negedge clock);
      s_status_valid = 1'b0;
      checkOutput("cpl_rsp_valid", rsp_valid, 1);
      checkOutput("cpl_rsp_status", rsp_status, eStatus);
      checkOutput("cpl_rsp_req", rsp_req, 64'(win));
      @(negedge clock);
      checkOutput("cpl_rsp_drop", rsp_valid, 0);
      checkOutput("cpl_idle", busy, 0);
   endtask

   initial begin
      logic [TW-1:0] eTag;
      bit            sawEarly;
      bit            stuckOk;

      rst            = 1'b1;
      tbl_wr_valid   = 1'b0;
      tbl_wr_id      = '0;
      tbl_wr_addr    = '0;
      tbl_wr_size    = '0;
      req_valid      = '0;
      req_id         = '0;
      m_desc_ready   = 1'b0;
      s_status_tag   = '0;
      s_status_error = '0;
      s_status_valid = 1'b0;
      applyReset();

      $display("[TB] reset values");
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_desc_valid", m_desc_valid, 0);
      checkOutput("rst_desc_addr", m_desc_addr, 0);
      checkOutput("rst_desc_len", m_desc_len, 0);
      checkOutput("rst_desc_tag", m_desc_tag, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_req", rsp_req, 0);
      checkOutput("rst_rsp_status", rsp_status, 0);

      $display("[TB] basic load, bad IDs, table edge cases");
      writeEntry(8'd3, 34'h1_0000_0000, 20'h04000);
      applyStimulus(2'b01, 8'd3, 8'd0, 0, 0, 1'b0, 1'b0, 4'd0);
      applyStimulus(2'b01, 8'd5, 8'd0, 0, 0, 1'b0, 1'b0, 4'd0);
      applyStimulus(2'b10, 8'd0, 8'd20, 0, 0, 1'b0, 1'b0, 4'd0);
      writeEntry(8'd0, 34'h0_1234_5600, 20'h00100);
      writeEntry(8'd16, 34'h0_0000_0000, 20'h00000);
      applyStimulus(2'b01, 8'd0, 8'd0, 0, 0, 1'b0, 1'b0, 4'd0);
      writeEntry(8'd3, 34'h0_0000_0000, 20'h00000);
      applyStimulus(2'b01, 8'd3, 8'd0, 0, 0, 1'b0, 1'b0, 4'd0);

      $display("[TB] alternation from reset");
      applyReset();
      writeEntry(8'd1, 34'h2_0000_0040, 20'h00800);
      writeEntry(8'd2, 34'h0_8000_0000, 20'h10000);
      for (int n = 0; n < 4; n++) begin
         applyStimulus(2'b11, 8'd1, 8'd2, 0, 0, 1'b0, 1'b0, 4'd0);
      end

      $display("[TB] stall, wrong tag, DMA error, bypass");
      applyStimulus(2'b01, 8'd1, 8'd0, 10, 0, 1'b1, 1'b1, 4'h2);
      applyStimulus(2'b10, 8'd0, 8'd7, 0, 1, 1'b0, 1'b0, 4'd0);
      applyStimulus(2'b01, 8'd2, 8'd0, 0, 2, 1'b0, 1'b0, 4'd0);

      $display("[TB] missing completion");
      writeEntry(8'd4, 34'h0_0004_0000, 20'h00200);
      req_valid = 2'b01;
      req_id    = {8'd0, 8'd4};
      @(negedge clock);
      req_valid = '0;
      mRr = 1;
      @(negedge clock);
      checkOutput("to_desc_valid", m_desc_valid, 1);
      m_desc_ready = 1'b1;
      @(negedge clock);
      m_desc_ready = 1'b0;
      eTag = TW'(mTag);
      mTag = (mTag + 1) % 256;
`ifdef RECON_SCHED_TIMEOUT_EN
      sawEarly = 1'b0;
      for (int c = 0; c < TO; c++) begin
         if (rsp_valid !== 1'b0) sawEarly = 1'b1;
         @(negedge clock);
      end
      checkOutput("to_not_early", sawEarly, 0);
      checkOutput("to_rsp_valid", rsp_valid, 1);
      checkOutput("to_rsp_status", rsp_status, 3);
      checkOutput("to_rsp_req", rsp_req, 0);
      @(negedge clock);
      s_status_valid = 1'b1;
      s_status_tag   = eTag;
      s_status_error = 4'd0;
      @(negedge clock);
      s_status_valid = 1'b0;
      checkOutput("to_late_cpl_ignored", rsp_valid, 0);
      checkOutput("to_idle", busy, 0);
`else
      sawEarly = 1'b0;
      stuckOk  = 1'b1;
      for (int c = 0; c < 150; c++) begin
         if (rsp_valid !== 1'b0) sawEarly = 1'b1;
         if (busy !== 1'b1) stuckOk = 1'b0;
         @(negedge clock);
      end
      checkOutput("no_to_rsp", sawEarly, 0);
      checkOutput("no_to_still_busy", stuckOk, 1);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      modelReset();
      checkOutput("wait_rst_idle", busy, 0);
      s_status_valid = 1'b1;
      s_status_tag   = eTag;
      s_status_error = 4'd0;
      @(negedge clock);
      s_status_valid = 1'b0;
      checkOutput("wait_rst_late_cpl", rsp_valid, 0);
`endif

      $display("[TB] reset during ISSUE");
      applyReset();
      writeEntry(8'd6, 34'h0_0600_0000, 20'h00600);
      req_valid = 2'b10;
      req_id    = {8'd6, 8'd0};
      @(negedge clock);
      req_valid = '0;
      @(negedge clock);
      checkOutput("ri_desc_valid", m_desc_valid, 1);
      rst = 1'b1;
      @(negedge clock);
      checkOutput("ri_desc_dropped", m_desc_valid, 0);
      checkOutput("ri_busy", busy, 0);
      rst = 1'b0;
      modelReset();
      s_status_valid = 1'b1;
      s_status_tag   = '0;
      s_status_error = 4'd0;
      @(negedge clock);
      s_status_valid = 1'b0;
      checkOutput("ri_late_cpl", rsp_valid, 0);
      checkOutput("ri_idle", busy, 0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(1, 0) == 1) begin
            writeEntry(8'($urandom_range(19, 0)), randAddr(),
                       ($urandom_range(4, 0) == 0) ? 20'h0 : LW'($urandom_range(1048575, 1)));
         end
         applyStimulus(2'($urandom_range(3, 1)),
                       8'($urandom_range(19, 0)), 8'($urandom_range(19, 0)),
                       $urandom_range(3, 0),
                       ($urandom_range(5, 0) == 0) ? int'($urandom_range(2, 1)) : 0,
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
